// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter that shares one uart_tx byte transmitter
// among NREQ requesters, with an idle watchdog that revokes a stalled grant.
module uart_tx_arbiter #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned IDLE_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [8*NREQ-1:0]    req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ready,
    output logic                 tx_data_we,
    output logic [7:0]           tx_data,
    input  logic                 tx_data_wait,
    output logic                 grant_valid,
    output logic [2:0]           grant_id,
    output logic                 timeout_err
);

    localparam int unsigned CNT_W  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t             state;
    logic [2:0]         rr_ptr;
    logic [CNT_W-1:0]   idle_cnt;

    logic               pick_found;
    logic [2:0]         pick_id;
    logic [3:0]         best_off;
    logic [3:0]         off;
    logic               hold_valid;
    logic               hold_last;
    logic [BYTE_W-1:0]  hold_data;
    logic               locked;
    logic               accept;
    logic [2:0]         next_ptr;

    // Arbitration picks the valid requester at the smallest distance past rr_ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = 3'd0;
        best_off   = 4'(NREQ);
        off        = 4'd0;
        for (int i = 0; i < int'(NREQ); i++) begin
            off = (3'(i) >= rr_ptr) ? 4'(i) - {1'b0, rr_ptr}
                                    : 4'(i + int'(NREQ)) - {1'b0, rr_ptr};
            if (req_valid[i] && (off < best_off)) begin
                best_off   = off;
                pick_id    = 3'(i);
                pick_found = 1'b1;
            end
        end
    end

    // Holder path; outputs are gated by resetn so the transmitter is released at once.
    always_comb begin
        hold_valid = 1'b0;
        hold_last  = 1'b0;
        hold_data  = '0;
        req_ready  = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_id == 3'(i)) begin
                hold_valid = req_valid[i];
                hold_last  = req_last[i];
                hold_data  = req_data[BYTE_W*i +: BYTE_W];
            end
        end
        locked     = resetn && (state == S_LOCKED);
        tx_data_we = locked && hold_valid;
        tx_data    = tx_data_we ? hold_data : 8'h00;
        accept     = tx_data_we && !tx_data_wait;
        for (int i = 0; i < int'(NREQ); i++) begin
            req_ready[i] = accept && (grant_id == 3'(i));
        end
        next_ptr = (grant_id == 3'(NREQ - 1)) ? 3'd0 : grant_id + 3'd1;
    end

    assign grant_valid = (state == S_LOCKED);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_IDLE;
            rr_ptr      <= 3'd0;
            grant_id    <= 3'd0;
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        state    <= S_LOCKED;
                        grant_id <= pick_id;
                        idle_cnt <= '0;
                    end
                end
                S_LOCKED: begin
                    if (accept && hold_last) begin
                        state    <= S_IDLE;
                        grant_id <= 3'd0;
                        rr_ptr   <= next_ptr;
                        idle_cnt <= '0;
                    end else if (hold_valid) begin
                        // Busy transmitter or accepted byte both count as activity.
                        idle_cnt <= '0;
                    end else if (idle_cnt == CNT_W'(IDLE_TIMEOUT - 1)) begin
                        state       <= S_IDLE;
                        grant_id    <= 3'd0;
                        rr_ptr      <= next_ptr;
                        idle_cnt    <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner
// sequences and randomized traffic against a packet-level reference model.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 64;

    logic                clk;
    logic                resetn;
    logic [NREQ-1:0]     req_valid;
    logic [8*NREQ-1:0]   req_data;
    logic [NREQ-1:0]     req_last;
    logic [NREQ-1:0]     req_ready;
    logic                tx_data_we;
    logic [7:0]          tx_data;
    logic                tx_data_wait;
    logic                grant_valid;
    logic [2:0]          grant_id;
    logic                timeout_err;

    int checks   = 0;
    int failures = 0;

    uart_tx_arbiter #(.NREQ(NREQ), .IDLE_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data_we   (tx_data_we),
        .tx_data      (tx_data),
        .tx_data_wait (tx_data_wait),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        logic        w;
        int          gv;
        int          gid;
        int          we;
        int          td;
        int          rdy;
        int          terr;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input int gv, input int gid, input int we,
                           input int td, input int rdy, input int terr);
        chk({tag, "_grant_valid"}, 32'(grant_valid), gv);
        chk({tag, "_grant_id"},    32'(grant_id),    gid);
        chk({tag, "_tx_data_we"},  32'(tx_data_we),  we);
        chk({tag, "_tx_data"},     32'(tx_data),     td);
        chk({tag, "_req_ready"},   32'(req_ready),   rdy);
        chk({tag, "_timeout_err"}, 32'(timeout_err), terr);
    endtask

    task automatic set_in(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                          input logic w);
        @(negedge clk);
        req_valid    = v;
        req_data     = d;
        req_last     = l;
        tx_data_wait = w;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn       = 1'b0;
        req_valid    = '0;
        req_data     = '0;
        req_last     = '0;
        tx_data_wait = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Reference model: owner of the transmitter, rotation start and count of
    // consecutive cycles the owner has presented nothing.
    int m_owner;
    int m_ptr;
    int m_quiet;
    bit m_terr;

    task automatic model_expect(output int gv, output int gid, output int we, output int td,
                                output int rdy, output int terr);
        gv   = (m_owner >= 0) ? 1 : 0;
        gid  = (m_owner >= 0) ? m_owner : 0;
        we   = 0;
        td   = 0;
        rdy  = 0;
        terr = m_terr ? 1 : 0;
        if (resetn && m_owner >= 0 && req_valid[m_owner]) begin
            we = 1;
            td = int'(req_data[8*m_owner +: 8]);
            if (!tx_data_wait) rdy = 1 << m_owner;
        end
    endtask

    task automatic model_step(input int rdy);
        if (!resetn) begin
            m_owner = -1;
            m_ptr   = 0;
            m_quiet = 0;
            m_terr  = 1'b0;
        end else begin
            m_terr = 1'b0;
            if (m_owner < 0) begin
                for (int k = NREQ - 1; k >= 0; k--) begin
                    if (req_valid[(m_ptr + k) % NREQ]) m_owner = (m_ptr + k) % NREQ;
                end
                m_quiet = 0;
            end else if (rdy != 0 && req_last[m_owner]) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end else if (req_valid[m_owner]) begin
                m_quiet = 0;
            end else begin
                m_quiet++;
                if (m_quiet == TMO) begin
                    m_terr  = 1'b1;
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_owner = -1;
                    m_quiet = 0;
                end
            end
        end
    endtask

    bit        g_busy [NREQ];
    logic [7:0] g_data [NREQ];
    bit        g_last [NREQ];
    int        g_gap  [NREQ];

    initial begin
        int bad;
        int e_gv, e_gid, e_we, e_td, e_rdy, e_terr;

        resetn       = 1'b0;
        req_valid    = '0;
        req_data     = '0;
        req_last     = '0;
        tx_data_wait = 1'b0;

        // rst, valid, data, last, wait | grant_valid, grant_id, we, data, ready, timeout
        tbl[0]  = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 0, 0, 0, 'h00, 'b0000, 0};
        tbl[1]  = '{1'b1, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 0, 0, 0, 'h00, 'b0000, 0};
        tbl[2]  = '{1'b1, 4'b0001, 32'h0000_0041, 4'b0000, 1'b0, 0, 0, 0, 'h00, 'b0000, 0};
        tbl[3]  = '{1'b1, 4'b0001, 32'h0000_0041, 4'b0000, 1'b0, 1, 0, 1, 'h41, 'b0001, 0};
        tbl[4]  = '{1'b1, 4'b0001, 32'h0000_0042, 4'b0000, 1'b1, 1, 0, 1, 'h42, 'b0000, 0};
        tbl[5]  = '{1'b1, 4'b0001, 32'h0000_0042, 4'b0000, 1'b1, 1, 0, 1, 'h42, 'b0000, 0};
        tbl[6]  = '{1'b1, 4'b0001, 32'h0000_0042, 4'b0000, 1'b0, 1, 0, 1, 'h42, 'b0001, 0};
        tbl[7]  = '{1'b1, 4'b0001, 32'h0000_0043, 4'b0001, 1'b1, 1, 0, 1, 'h43, 'b0000, 0};
        tbl[8]  = '{1'b1, 4'b0001, 32'h0000_0043, 4'b0001, 1'b0, 1, 0, 1, 'h43, 'b0001, 0};
        tbl[9]  = '{1'b1, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 0, 0, 0, 'h00, 'b0000, 0};
        tbl[10] = '{1'b1, 4'b1111, 32'h3322_1100, 4'b1111, 1'b0, 0, 0, 0, 'h00, 'b0000, 0};
        tbl[11] = '{1'b1, 4'b1111, 32'h3322_1100, 4'b1111, 1'b0, 1, 1, 1, 'h11, 'b0010, 0};
        tbl[12] = '{1'b1, 4'b1111, 32'h3322_1100, 4'b1111, 1'b0, 0, 0, 0, 'h00, 'b0000, 0};
        tbl[13] = '{1'b1, 4'b1111, 32'h3322_1100, 4'b1111, 1'b0, 1, 2, 1, 'h22, 'b0100, 0};
        tbl[14] = '{1'b1, 4'b1111, 32'h3322_1100, 4'b1111, 1'b0, 0, 0, 0, 'h00, 'b0000, 0};
        tbl[15] = '{1'b1, 4'b1111, 32'h3322_1100, 4'b1111, 1'b0, 1, 3, 1, 'h33, 'b1000, 0};
        tbl[16] = '{1'b1, 4'b1111, 32'h3322_1100, 4'b1111, 1'b0, 0, 0, 0, 'h00, 'b0000, 0};
        tbl[17] = '{1'b1, 4'b1111, 32'h3322_1100, 4'b1111, 1'b0, 1, 0, 1, 'h00, 'b0001, 0};
        tbl[18] = '{1'b1, 4'b1111, 32'h3322_1100, 4'b1111, 1'b0, 0, 0, 0, 'h00, 'b0000, 0};
        tbl[19] = '{1'b1, 4'b1111, 32'h3322_1100, 4'b1111, 1'b0, 1, 1, 1, 'h11, 'b0010, 0};
        tbl[20] = '{1'b1, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 0, 0, 0, 'h00, 'b0000, 0};

        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            resetn       = tbl[i].rst;
            req_valid    = tbl[i].v;
            req_data     = tbl[i].d;
            req_last     = tbl[i].l;
            tx_data_wait = tbl[i].w;
            #1;
            chk_out($sformatf("vec%0d", i), tbl[i].gv, tbl[i].gid, tbl[i].we,
                    tbl[i].td, tbl[i].rdy, tbl[i].terr);
        end

        // Watchdog revokes a stalled holder; the next requester in rotation follows.
        do_reset();
        set_in(4'b1100, 32'hAA10_0000, 4'b0000, 1'b0);
        chk_out("s3_idle", 0, 0, 0, 0, 0, 0);
        set_in(4'b1100, 32'hAA10_0000, 4'b0000, 1'b0);
        chk_out("s3_grant", 1, 2, 1, 'h10, 'b0100, 0);
        bad = 0;
        for (int i = 0; i < TMO; i++) begin
            set_in(4'b1000, 32'hAA10_0000, 4'b0000, 1'b0);
            if (timeout_err !== 1'b0 || grant_valid !== 1'b1 || grant_id !== 3'd2) bad++;
        end
        chk("s3_hold_before_expiry", 32'(bad), 0);
        set_in(4'b1000, 32'hAA10_0000, 4'b0000, 1'b0);
        chk_out("s3_expire", 0, 0, 0, 0, 0, 1);
        set_in(4'b1000, 32'hAA10_0000, 4'b0000, 1'b0);
        chk_out("s3_next", 1, 3, 1, 'hAA, 'b1000, 0);

        // New request arriving with the holder's last byte waits behind the rotation.
        do_reset();
        set_in(4'b1100, 32'h3320_0000, 4'b0100, 1'b1);
        chk_out("s4_idle", 0, 0, 0, 0, 0, 0);
        set_in(4'b1100, 32'h3320_0000, 4'b0100, 1'b1);
        chk_out("s4_lock", 1, 2, 1, 'h20, 'b0000, 0);
        set_in(4'b1110, 32'h3320_1100, 4'b0100, 1'b0);
        chk_out("s4_last", 1, 2, 1, 'h20, 'b0100, 0);
        set_in(4'b1010, 32'h3320_1100, 4'b0000, 1'b0);
        chk_out("s4_gap", 0, 0, 0, 0, 0, 0);
        set_in(4'b1010, 32'h3320_1100, 4'b0000, 1'b0);
        chk_out("s4_rr", 1, 3, 1, 'h33, 'b1000, 0);

        // A long-busy transmitter never trips the watchdog.
        do_reset();
        set_in(4'b0001, 32'h0000_0055, 4'b0001, 1'b1);
        chk_out("s5_idle", 0, 0, 0, 0, 0, 0);
        bad = 0;
        for (int i = 0; i < 5000; i++) begin
            set_in(4'b0001, 32'h0000_0055, 4'b0001, 1'b1);
            if (timeout_err !== 1'b0 || req_ready !== 4'b0000 ||
                grant_valid !== 1'b1 || tx_data_we !== 1'b1) bad++;
        end
        chk("s5_busy_hold", 32'(bad), 0);
        set_in(4'b0001, 32'h0000_0055, 4'b0001, 1'b0);
        chk_out("s5_accept", 1, 0, 1, 'h55, 'b0001, 0);
        set_in(4'b0000, 32'h0000_0000, 4'b0000, 1'b0);
        chk_out("s5_done", 0, 0, 0, 0, 0, 0);

        // Reset mid-packet drops the grant and restarts rotation at requester 0.
        do_reset();
        set_in(4'b0010, 32'h0000_7700, 4'b0010, 1'b0);
        set_in(4'b0010, 32'h0000_7700, 4'b0010, 1'b0);
        chk_out("s6_p1", 1, 1, 1, 'h77, 'b0010, 0);
        set_in(4'b0100, 32'h0099_0000, 4'b0000, 1'b0);
        chk_out("s6_gap", 0, 0, 0, 0, 0, 0);
        set_in(4'b0100, 32'h0099_0000, 4'b0000, 1'b0);
        chk_out("s6_p2", 1, 2, 1, 'h99, 'b0100, 0);
        set_in(4'b0100, 32'h009A_0000, 4'b0000, 1'b1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("s6_rst_we", 32'(tx_data_we), 0);
        chk("s6_rst_ready", 32'(req_ready), 0);
        @(negedge clk);
        resetn       = 1'b1;
        req_valid    = 4'b0101;
        req_data     = 32'h009A_00C0;
        req_last     = 4'b0000;
        tx_data_wait = 1'b0;
        #1;
        chk_out("s6_release", 0, 0, 0, 0, 0, 0);
        set_in(4'b0101, 32'h009A_00C0, 4'b0000, 1'b0);
        chk_out("s6_rearb", 1, 0, 1, 'hC0, 'b0001, 0);

        // Randomized traffic against the reference model.
        do_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_quiet = 0;
        m_terr  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            g_busy[i] = 1'b0;
            g_data[i] = 8'h00;
            g_last[i] = 1'b0;
            g_gap[i]  = int'($urandom_range(0, 3));
        end
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            resetn = ($urandom_range(0, 999) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!g_busy[i]) begin
                    if (g_gap[i] > 0) begin
                        g_gap[i]--;
                    end else begin
                        g_busy[i] = 1'b1;
                        g_data[i] = 8'($urandom);
                        g_last[i] = ($urandom_range(0, 2) == 0);
                    end
                end
                req_valid[i]        = g_busy[i];
                req_data[8*i +: 8]  = g_data[i];
                req_last[i]         = g_last[i];
            end
            tx_data_wait = ($urandom_range(0, 9) < 4);
            #1;
            model_expect(e_gv, e_gid, e_we, e_td, e_rdy, e_terr);
            chk_out("rnd", e_gv, e_gid, e_we, e_td, e_rdy, e_terr);
            model_step(e_rdy);
            for (int i = 0; i < NREQ; i++) begin
                if (e_rdy[i]) begin
                    if (g_last[i]) begin
                        g_busy[i] = 1'b0;
                        g_gap[i]  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(70, 90))
                                                                 : int'($urandom_range(0, 4));
                    end else if ($urandom_range(0, 19) == 0) begin
                        g_busy[i] = 1'b0;
                        g_gap[i]  = int'($urandom_range(50, 90));
                    end else begin
                        g_data[i] = 8'($urandom);
                        g_last[i] = ($urandom_range(0, 2) == 0);
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one uart_tx byte transmitter among NREQ requesters (e.g. loopback echo, status reporter, debug dumper).
Grants are packet-locked: once a requester wins, it keeps the transmitter until it sends a byte flagged last, or until its idle watchdog expires.
Sits between the requesters and the uart_tx data_we/data/data_wait interface.

Parameters:
NREQ, 4, number of requesters (2..8).
IDLE_TIMEOUT, 1024, cycles a granted requester may hold req_valid low mid-packet before the grant is revoked (>=2).

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
req_valid  input  NREQ  per-requester byte valid
req_data  input  8*NREQ  per-requester byte; requester i uses bits [8*i+7:8*i]
req_last  input  NREQ  per-requester end-of-packet flag, qualified by req_valid
req_ready  output  NREQ  per-requester byte accepted this cycle
tx_data_we  output  1  to uart_tx data_we
tx_data  output  8  to uart_tx data
tx_data_wait  input  1  from uart_tx data_wait (high = transmitter busy)
grant_valid  output  1  a requester currently holds the transmitter
grant_id  output  3  index of current holder; 0 when grant_valid=0
timeout_err  output  1  one-cycle pulse when a grant is revoked by the watchdog

Behaviour:
- Reset is resetn, synchronous, active-low; clock is clk. All state updates happen on posedge clk.
- Values while resetn=0 and on the first cycle after release:
  - state=IDLE, rr_ptr=0, grant_valid=0, grant_id=0, idle_cnt=0, timeout_err=0.
  - tx_data_we=0, tx_data=0, req_ready=0.
- State IDLE:
  - tx_data_we=0, tx_data=0, req_ready all 0.
  - If any req_valid is high, select the first set bit scanning rr_ptr, rr_ptr+1, ... wrapping mod NREQ.
  - Next cycle: state=LOCKED, grant_valid=1, grant_id=selected index, idle_cnt=0.
  - Arbitration latency: one cycle from req_valid rising to grant_valid.
  - A byte is never accepted in the same cycle it is arbitrated.
- State LOCKED, holder g:
  - tx_data_we = req_valid[g]. tx_data = req_data[g] when req_valid[g]=1, else 0. Both are combinational.
  - accept = req_valid[g] && !tx_data_wait. req_ready[g] = accept; all other req_ready bits are 0.
  - Requesters must hold valid/data/last stable until req_ready is high. Non-granted requesters wait with no side effects.
- On accept with req_last[g]=1:
  - Next cycle: state=IDLE, grant_valid=0, grant_id=0, rr_ptr=(g+1) mod NREQ.
- On accept with req_last[g]=0: remain LOCKED and clear idle_cnt.
- While LOCKED with req_valid[g]=0:
  - idle_cnt increments each cycle.
  - When idle_cnt reaches IDLE_TIMEOUT-1 and req_valid[g] is still 0, the next cycle applies: state=IDLE, grant_valid=0, rr_ptr=(g+1) mod NREQ, timeout_err=1 for exactly one cycle.
  - If req_valid[g] returns before expiry, clear idle_cnt.
- While req_valid[g]=1 and tx_data_wait=1, idle_cnt holds at 0. A busy transmitter never triggers the watchdog.
- Single-byte packet (req_last set on the first byte) is legal: LOCKED lasts until that one accept.
- Simultaneous events:
  - A new req_valid from another requester in the same cycle as the holder's last accept is arbitrated on the following IDLE cycle, starting from the updated rr_ptr.
  - The minimum gap between packets from different requesters is one IDLE cycle.
- Requester dropping req_valid without acceptance: legal but discouraged; the byte is simply not sent.
- resetn=0 mid-packet: the grant is dropped immediately and tx_data_we falls the same cycle.
  - A byte already latched by uart_tx finishes on the line. This is the transmitter's concern; the arbiter does not track it.
- Widths: idle_cnt is $clog2(IDLE_TIMEOUT) bits. rr_ptr and grant_id are 3 bits; upper bits are 0 when NREQ<8.
- Fairness: with all requesters continuously busy, grants rotate 0,1,2,...,NREQ-1,0. No requester waits more than NREQ-1 packets.

Test Plan:
1. Reset, then req_valid=4'b0001 with 3 bytes 0x41,0x42,0x43 (last on 0x43), tx_data_wait modelled as busy 10 bit-times per byte -> grant_id=0 one cycle after valid; tx_data shows 0x41,0x42,0x43 in order; one req_ready pulse per byte; grant_valid drops after the 0x43 accept; rr_ptr=1.
2. req_valid=4'b1111, every requester sends a 1-byte packet repeatedly -> grant_id sequence 0,1,2,3,0; exactly one IDLE cycle between grants.
3. Requester 2 holds the grant, sends 0x10 (not last), then drops req_valid for IDLE_TIMEOUT cycles -> timeout_err pulses once; grant_valid=0; the next grant goes to requester 3 if it is valid.
4. Holder's last accept coincides with requester 1 raising req_valid while rr_ptr becomes 3 and requester 3 is also valid -> requester 3 is granted before requester 1.
5. tx_data_wait held high for 5000 cycles (> IDLE_TIMEOUT) with the holder valid -> no timeout_err, no req_ready; the byte is accepted the first cycle tx_data_wait falls.
6. resetn pulled low for one cycle mid-packet -> next cycle grant_valid=0, tx_data_we=0, req_ready=0, rr_ptr=0; the arbiter then re-arbitrates normally.
